// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with a 3-sample majority vote,
// 2-flop input synchroniser and a show-ahead FIFO for received words.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle, waiting for a low sample (or for a high bit after a break)
// START   | validating the start bit, glitches return to IDLE
// DATA    | shifting data bits in LSB first
// PARITY  | checking the parity bit
// STOP    | checking stop bit(s); word pushed at the last stop decision
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  input  logic                 clr_overrun,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_break
);

  localparam int TICK_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int BW       = $clog2(DATA_BITS);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int EW       = DATA_BITS + 2;

  localparam logic [SW-1:0] S_M0   = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_M1   = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic rx_meta_q, rx_s_q;
  logic [TW-1:0] tcnt_q;
  logic tick;

  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d, s_next;
  logic [BW-1:0] bit_q, bit_d;
  logic stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0] smp_q, smp_d;
  logic frame_err_q, frame_err_d;
  logic par_err_q, par_err_d;
  logic maj;
  logic push;
  logic [EW-1:0] push_word;

`ifdef UART_RX_BREAK_DET_EN
  logic all_zero_q, all_zero_d;
  logic brk_wait_q, brk_wait_d;
  logic brk_q, brk_d;
`endif

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic empty, full, pop, accept, drop;
  logic overrun_q;
  logic [EW-1:0] head;

  // Two-flop synchroniser for the asynchronous serial line, idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick = (tcnt_q == TW'(TICK_DIV - 1));

  // Free-running oversample tick divider.
  always_ff @(posedge clk) begin
    if (rst || tick) tcnt_q <= '0;
    else             tcnt_q <= tcnt_q + 1'b1;
  end

  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

  // Receiver FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shreg_q     <= '0;
      smp_q       <= 2'b11;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      all_zero_q  <= 1'b0;
      brk_wait_q  <= 1'b0;
      brk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      shreg_q     <= shreg_d;
      smp_q       <= smp_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
`ifdef UART_RX_BREAK_DET_EN
      all_zero_q  <= all_zero_d;
      brk_wait_q  <= brk_wait_d;
      brk_q       <= brk_d;
`endif
    end
  end

  // Next-state logic; everything advances only on oversample ticks.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shreg_d     = shreg_q;
    smp_d       = smp_q;
    frame_err_d = frame_err_q;
    par_err_d   = par_err_q;
    push        = 1'b0;
    push_word   = {par_err_q, frame_err_q, shreg_q};
    s_next      = (s_q == S_LAST) ? '0 : s_q + 1'b1;
`ifdef UART_RX_BREAK_DET_EN
    all_zero_d  = all_zero_q;
    brk_wait_d  = brk_wait_q;
    brk_d       = 1'b0;
`endif
    if (tick) begin
      if (s_q == S_M0) smp_d[0] = rx_s_q;
      if (s_q == S_M1) smp_d[1] = rx_s_q;
      case (state_q)
        ST_IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
          // After a break the line must stay high for a whole bit first.
          if (brk_wait_q) begin
            if (!rx_s_q) begin
              s_d = '0;
            end else if (s_q == S_LAST) begin
              brk_wait_d = 1'b0;
              s_d        = '0;
            end else begin
              s_d = s_next;
            end
          end else
`endif
          if (!rx_s_q) begin
            state_d     = ST_START;
            s_d         = SW'(1);
            bit_d       = '0;
            stop_d      = 1'b0;
            frame_err_d = 1'b0;
            par_err_d   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            all_zero_d  = 1'b1;
`endif
          end
        end
        ST_START: begin
          s_d = s_next;
          if (s_q == S_DEC && maj) begin
            state_d = ST_IDLE;
            s_d     = '0;
          end else if (s_q == S_LAST) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          s_d = s_next;
          if (s_q == S_DEC) begin
            shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DET_EN
            all_zero_d = all_zero_q & ~maj;
`endif
          end
          if (s_q == S_LAST) begin
            if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            else                             bit_d   = bit_q + 1'b1;
          end
        end
        ST_PARITY: begin
          s_d = s_next;
          if (s_q == S_DEC) begin
            par_err_d = (PARITY == 1) ? ~(^shreg_q ^ maj) : (^shreg_q ^ maj);
`ifdef UART_RX_BREAK_DET_EN
            all_zero_d = all_zero_q & ~maj;
`endif
          end
          if (s_q == S_LAST) state_d = ST_STOP;
        end
        ST_STOP: begin
          s_d = s_next;
          if (s_q == S_DEC) begin
            frame_err_d = frame_err_q | ~maj;
            // Return to IDLE mid-bit so the next start edge is never missed.
            if (stop_q == 1'(STOP_BITS - 1)) begin
              state_d   = ST_IDLE;
              s_d       = '0;
              push      = 1'b1;
              push_word = {par_err_q, frame_err_q | ~maj, shreg_q};
            end
`ifdef UART_RX_BREAK_DET_EN
            if (!stop_q && all_zero_q && !maj) begin
              push       = 1'b0;
              brk_d      = 1'b1;
              brk_wait_d = 1'b1;
              state_d    = ST_IDLE;
              s_d        = '0;
            end
`endif
          end else if (s_q == S_LAST) begin
            stop_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          s_d     = '0;
        end
      endcase
    end
  end

  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop    = !empty && rx_ready;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
    end
  end

  // FIFO storage; stale contents are masked by rx_valid on the outputs.
  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[wr_q[AW-1:0]] <= push_word;
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst)              overrun_q <= 1'b0;
    else if (drop)        overrun_q <= 1'b1;
    else if (clr_overrun) overrun_q <= 1'b0;
  end

  assign head          = mem_q[rd_q[AW-1:0]];
  assign rx_valid      = !empty;
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_frame_err  = rx_valid & head[DATA_BITS];
  assign rx_parity_err = rx_valid & head[DATA_BITS+1];
  assign rx_overrun    = overrun_q;

`ifdef UART_RX_BREAK_DET_EN
  assign rx_break = brk_q;
`else
  assign rx_break = 1'b0;
`endif

endmodule
